// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receiver (2-FF sync, glitch-rejecting start, stop check) feeding a valid/ready FIFO.
// Optional `define UART_RX_PARITY_EN selects 8E1 framing; default build is 8N1.
module uart_rx_buffered #(
   parameter int CLKS_PER_BIT = 20,
   parameter int FIFO_AW      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       overflow,
   output logic [7:0] frame_err_cnt,
   input  logic       err_clear
);
   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam int            DEPTH     = 2 ** FIFO_AW;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       sync_q, sync_d;
   logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
   logic             par_bad_q, par_bad_d;
`endif
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic [7:0]       mem_q [DEPTH];

   logic line, bit_tick, push_req, frame_err;
   logic fifo_empty, fifo_full, pop, do_push;

   assign sync_d   = {sync_q[0], uart_data};
   assign line     = sync_q[1];
   assign bit_tick = (clk_cnt_q == BIT_LAST);

   // State register: every flop of the receiver and FIFO control.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q    <= S_IDLE;
         sync_q     <= 2'b11;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad_q  <= 1'b0;
`endif
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q  <= par_bad_d;
`endif
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Next-state logic; all samples land mid-bit, counted from the middle of the start bit.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            if (!line) begin
               state_d   = S_START;
               bit_cnt_d = '0;
            end
         end
         S_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = '0;
               state_d   = line ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               shift_d   = {line, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               par_bad_d = line ^ (^shift_q);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               state_d   = line ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            clk_cnt_d = '0;
            if (line) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: stop-bit verdict, FIFO pointer moves and error bookkeeping.
   always_comb begin
      push_req = 1'b0;
      frame_err = 1'b0;
      if (state_q == S_STOP && bit_tick) begin
`ifdef UART_RX_PARITY_EN
         frame_err = ~line | par_bad_q;
`else
         frame_err = ~line;
`endif
         push_req = ~frame_err;
      end

      wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d = overflow_q | (push_req & fifo_full & ~pop);
      err_cnt_d  = err_cnt_q;
      if (frame_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
      if (err_clear) begin
         overflow_d = 1'b0;
         err_cnt_d  = '0;
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign pop        = rx_valid & rx_ready;
   assign do_push    = push_req & (~fifo_full | pop);

   // NOTE: storage is not reset; rx_data is forced to 0 while empty so stale entries never show.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
   end

   assign rx_valid      = ~fifo_empty;
   assign rx_data       = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign overflow      = overflow_q;
   assign frame_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: stimulus queues expected bytes, an independent monitor pops and compares.
module tb_uart_rx_buffered;
   localparam int CPB   = 20;
   localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // Clock edge, counted from the start-bit falling edge, at which the stop bit is judged:
   // two sync stages, one detect cycle, half a bit to mid-start, then the remaining bits.
   localparam int STOP_EDGE = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB;

   logic       clk = 1'b0;
   logic       reset, uart_data, rx_ready, err_clear;
   logic [7:0] rx_data, frame_err_cnt;
   logic       rx_valid, overflow;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   logic [7:0] rbyte;
   bit         rand_done;

   uart_rx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .uart_data     (uart_data),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .overflow      (overflow),
      .frame_err_cnt (frame_err_cnt),
      .err_clear     (err_clear)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b, input int n);
      uart_data = b;
      repeat (n) @(negedge clk);
   endtask

   // Serial frame, LSB first; parity (8E1 builds) is even unless par_flip is set.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit = 1'b1,
                             input logic par_flip = 1'b0);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip, CPB);
`else
      if (par_flip) drive_bit(1'b1, 0);
`endif
      drive_bit(stop_bit, CPB);
      uart_data = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b);
      exp_q.push_back(b);
      send_frame(b);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("drain_all_expected", exp_q.size(), 0);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!rx_valid && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("valid_seen", rx_valid, 1);
   endtask

   // Monitor: every accepted byte must be the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!reset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_byte: got %0h, expected none", rx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               check("rx_byte", rx_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #(10 * 100_000);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; uart_data = 1'b1; rx_ready = 1'b1; err_clear = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_overflow", overflow, 0);
      check("reset_err_cnt", frame_err_cnt, 0);
      reset = 1'b0;
      idle_cycles(5);

      // Pulse mode: each byte shows rx_valid for exactly one cycle.
      fork
         begin send_good(8'h13); send_good(8'hA5); end
         begin
            for (int n = 0; n < 2; n++) begin
               wait_valid(2 * FRAME_BITS * CPB);
               @(negedge clk);
               check("valid_one_cycle", rx_valid, 0);
            end
         end
      join
      wait_drain(4 * CPB);

      // Overflow: ready low, five bytes into four slots.
      rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
         send_frame(8'(i));
      end
      idle_cycles(CPB);
      check("overflow_set", overflow, 1);
      check("head_held_valid", rx_valid, 1);
      check("head_held_data", rx_data, exp_q[0]);
      rx_ready = 1'b1;
      wait_drain(4 * CPB);
      check("overflow_sticky", overflow, 1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("overflow_cleared", overflow, 0);

      // Full FIFO, push and pop in the same cycle: no loss, no overflow.
      rx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_good(8'(8'h11 + i));
      exp_q.push_back(8'h15);
      fork
         send_frame(8'h15);
         begin
            repeat (STOP_EDGE - 1) @(posedge clk);
            @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
         end
      join
      idle_cycles(2);
      check("full_push_pop_no_ovf", overflow, 0);
      check("full_push_pop_count", exp_q.size(), DEPTH);
      rx_ready = 1'b1;
      wait_drain(4 * CPB);

      // Framing error: bad stop bit drops the byte; the next byte still arrives.
      send_frame(8'h3C, 1'b0);
      idle_cycles(CPB);
      check("frame_err_count", frame_err_cnt, 1);
      send_good(8'h22);
      wait_drain(4 * CPB);

      // err_clear asserted in the very cycle of another framing error wins.
      fork
         send_frame(8'h55, 1'b0);
         begin
            repeat (STOP_EDGE - 1) @(posedge clk);
            @(negedge clk);
            err_clear = 1'b1;
            @(negedge clk);
            err_clear = 1'b0;
         end
      join
      idle_cycles(CPB);
      check("clear_beats_error", frame_err_cnt, 0);

      // Short low glitch on an idle line is ignored.
      drive_bit(1'b0, 5);
      drive_bit(1'b1, 3 * CPB);
      check("glitch_no_error", frame_err_cnt, 0);
      check("glitch_no_byte", rx_valid, 0);
      send_good(8'h5A);
      wait_drain(4 * CPB);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      idle_cycles(CPB);
      check("parity_err_count", frame_err_cnt, 1);
      send_good(8'h07);
      wait_drain(4 * CPB);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
`endif

      // Random bytes, random gaps, random consumer backpressure.
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               rbyte = 8'($urandom);
               send_good(rbyte);
               idle_cycles(int'($urandom_range(0, CPB)));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               rx_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      rx_ready = 1'b1;
      wait_drain(4 * CPB);
      check("random_no_error", frame_err_cnt, 0);
      check("random_no_overflow", overflow, 0);

      // Counter saturation: held-low frames, one error each.
      for (int i = 0; i < 256; i++) begin
         drive_bit(1'b0, FRAME_BITS * CPB);
         drive_bit(1'b1, CPB / 4);
         if (i == 254) check("err_cnt_255", frame_err_cnt, 8'hFF);
      end
      idle_cycles(CPB);
      check("err_cnt_saturated", frame_err_cnt, 8'hFF);

      // Reset mid-byte with a full FIFO and both flags set.
      rx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(8'(8'h31 + i));
         send_frame(8'(8'h31 + i));
      end
      idle_cycles(CPB);
      check("pre_reset_overflow", overflow, 1);
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
      reset = 1'b1;
      uart_data = 1'b1;
      exp_q.delete();
      idle_cycles(3);
      check("mid_reset_overflow", overflow, 0);
      check("mid_reset_err_cnt", frame_err_cnt, 0);
      check("mid_reset_fifo_empty", rx_valid, 0);
      reset = 1'b0;
      idle_cycles(CPB);
      rx_ready = 1'b1;
      send_good(8'h7E);
      wait_drain(4 * CPB);
      check("post_reset_overflow", overflow, 0);
      check("post_reset_err_cnt", frame_err_cnt, 0);

      idle_cycles(10);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
